// File: rtl/sha256_msg_schedule_if.sv
// Port bundle for the SHA-256 message-schedule expander: block input words in,
// schedule words W[t] out, plus the control/status strobes.
interface sha256_msg_schedule_if;
  // Both word ports use valid/ready: a transfer happens on a rising clock edge
  // where valid && ready; valid never waits on ready, and the sender holds the
  // payload stable while valid is high and ready is low.
  logic        start;
  logic [31:0] word_in;
  logic        word_in_valid;
  logic        word_in_ready;
  logic [31:0] w_out;
  logic [5:0]  w_index;
  logic        w_valid;
  logic        w_ready;
  logic        busy;
  logic        done;

  modport master (
    output start, word_in, word_in_valid, w_ready,
    input  word_in_ready, w_out, w_index, w_valid, busy, done
  );

  modport slave (
    input  start, word_in, word_in_valid, w_ready,
    output word_in_ready, w_out, w_index, w_valid, busy, done
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: takes the 16 words of one padded block and
// streams W[0..63] in round order through a single output register.
module sha256_msg_schedule (
  input  logic                         clock,
  input  logic                         reset,
  sha256_msg_schedule_if.slave         bus,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] wnd [16];
  logic [5:0]  t;
  logic [31:0] w_out_q;
  logic [5:0]  w_index_q;
  logic        w_valid_q;
  logic        done_q, done_d;
  logic        slot_free;
  logic        in_ready;
  logic        load;
  logic        clear_t;
  logic [31:0] load_data;
  logic [31:0] expand_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // wnd[15] is W[t-1] and wnd[0] is W[t-16], so the taps are t-2, t-7, t-15, t-16.
  assign expand_word = sigma1(wnd[14]) + wnd[9] + sigma0(wnd[1]) + wnd[0];
  assign slot_free   = !w_valid_q || bus.w_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    load      = 1'b0;
    clear_t   = 1'b0;
    load_data = bus.word_in;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          clear_t = 1'b1;
        end
      end
      LOAD: begin
        in_ready = slot_free;
        if (bus.word_in_valid && slot_free) begin
          load = 1'b1;
          if (t == 6'd15) state_d = EXPAND;
        end
      end
      EXPAND: begin
        load_data = expand_word;
        if (slot_free) begin
          load = 1'b1;
          if (t == 6'd63) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (w_valid_q && bus.w_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      t         <= '0;
      w_out_q   <= '0;
      w_index_q <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) wnd[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (clear_t) t <= '0;
      if (load) begin
        for (int i = 0; i < 15; i++) wnd[i] <= wnd[i+1];
        wnd[15]   <= load_data;
        w_out_q   <= load_data;
        w_index_q <= t;
        w_valid_q <= 1'b1;
        t         <= t + 6'd1;
      end else if (w_valid_q && bus.w_ready) begin
        w_valid_q <= 1'b0;
      end
    end
  end

  assign bus.word_in_ready = in_ready;
  assign bus.w_out         = w_out_q;
  assign bus.w_index       = w_index_q;
  assign bus.w_valid       = w_valid_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: known "abc" schedule, stalls, gaps,
// mid-block reset, ignored start/valid strobes and back-to-back blocks.
module tb_sha256_msg_schedule;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_EXPND = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic       clock;
  logic       reset;
  logic [1:0] state_dbg;

  sha256_msg_schedule_if bus();

  sha256_msg_schedule dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [37:0] exp_q[$];
  logic [31:0] cur_blk [16];
  logic [31:0] exp_w [64];
  bit          awaiting_done = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_out;
  logic [5:0]  prev_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_expect(input bit abc);
    for (int i = 0; i < 16; i++) exp_w[i] = cur_blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
    if (abc) begin
      exp_w[16] = 32'h61626380;
      exp_w[17] = 32'h000F0000;
      exp_w[18] = 32'h7DA86405;
    end
    for (int i = 0; i < 64; i++) begin
      logic [5:0] ix;
      ix = i[5:0];
      exp_q.push_back({ix, exp_w[i]});
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, bus.w_valid}, 32'd1);
        check("hold_data", bus.w_out, prev_out);
        check("hold_index", {26'd0, bus.w_index}, {26'd0, prev_idx});
      end
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          logic [37:0] e;
          e = exp_q.pop_front();
          check("w_out", bus.w_out, e[31:0]);
          check("w_index", {26'd0, bus.w_index}, {26'd0, e[37:32]});
          if (e[37:32] == 6'd63) awaiting_done = 1;
        end
      end
      if (bus.done) begin
        check("done_expected", {31'd0, awaiting_done}, 32'd1);
        awaiting_done = 0;
      end
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_out   = bus.w_out;
      prev_idx   = bus.w_index;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_abc();
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'd0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom();
  endtask

  task automatic run_block(input bit abc, input int gap_pct, input int stall_pct,
                           input bit directed_stall, input bit noise_start,
                           input bit late_start, input int abort_idx,
                           output int done_cyc, output int first_cyc);
    int widx, c, hold14, hold63;
    bit acc, got_done;
    widx = 0; c = 0; hold14 = 0; hold63 = 0; got_done = 0;
    done_cyc = -1; first_cyc = -1;
    build_expect(abc);
    while (!got_done && c < 600) begin
      if (abort_idx >= 0 && bus.w_valid && bus.w_index == abort_idx[5:0]) return;
      bus.start = (c == 0)
               || (noise_start && (state_dbg == S_LOAD || state_dbg == S_EXPND) && $urandom_range(3) == 0)
               || (late_start && state_dbg == S_FLUSH);
      bus.word_in_valid = (widx < 16) && ($urandom_range(99) >= gap_pct);
      if (bus.word_in_valid) bus.word_in = cur_blk[widx];
      else                   bus.word_in = $urandom();
      bus.w_ready = ($urandom_range(99) >= stall_pct);
      if (directed_stall && bus.w_valid) begin
        if (bus.w_index == 6'd14 && hold14 < 10) begin bus.w_ready = 1'b0; hold14++; end
        if (bus.w_index == 6'd63 && hold63 < 10) begin bus.w_ready = 1'b0; hold63++; end
      end
      @(negedge clock);
      acc = bus.word_in_valid && bus.word_in_ready;
      if (bus.w_valid && first_cyc < 0) first_cyc = c;
      if (directed_stall && !bus.w_ready && bus.w_valid && bus.w_index == 6'd14)
        check("load_stall_ready", {31'd0, bus.word_in_ready}, 32'd0);
      if (directed_stall && !bus.w_ready && bus.w_valid && bus.w_index == 6'd63)
        check("stall63_no_done", {31'd0, bus.done}, 32'd0);
      if (bus.done) begin got_done = 1; done_cyc = c; end
      @(posedge clock); #1;
      if (acc) widx++;
      c++;
    end
    bus.start = 1'b0;
    bus.word_in_valid = 1'b0;
    if (!got_done) check("block_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_w_out"}, bus.w_out, 32'd0);
    check({tag, "_w_index"}, {26'd0, bus.w_index}, 32'd0);
    check({tag, "_w_valid"}, {31'd0, bus.w_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, bus.word_in_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, S_IDLE});
  endtask

  task automatic idle_noise();
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'b0;
      bus.word_in_valid = 1'b1;
      bus.word_in = $urandom();
      bus.w_ready = $urandom_range(1);
      @(negedge clock);
      check("idle_in_ready", {31'd0, bus.word_in_ready}, 32'd0);
      check("idle_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
      check("idle_w_valid", {31'd0, bus.w_valid}, 32'd0);
      @(posedge clock); #1;
    end
    bus.word_in_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dc, fc;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.word_in = '0;
    bus.word_in_valid = 1'b0;
    bus.w_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_values("reset");

    idle_noise();

    // "abc" at full rate, with a start strobe during FLUSH that must be ignored
    load_abc();
    run_block(1, 0, 0, 0, 0, 1, -1, dc, fc);
    check("abc_first_valid_cycle", fc, 32'd2);
    check("abc_done_cycle", dc, 32'd66);
    check("abc_q_empty", exp_q.size(), 32'd0);
    check("abc_after_busy", {31'd0, bus.busy}, 32'd0);
    check("abc_after_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

    // back-to-back block started in the cycle after done
    load_random();
    run_block(0, 0, 0, 0, 0, 0, -1, dc, fc);
    check("b2b_done_cycle", dc, 32'd66);
    check("b2b_q_empty", exp_q.size(), 32'd0);

    // random blocks with input gaps, output stalls and stray start strobes
    for (int k = 0; k < 3; k++) begin
      load_random();
      run_block(0, 30, 30, 0, 1, 0, -1, dc, fc);
      check("rand_q_empty", exp_q.size(), 32'd0);
      check("rand_busy_low", {31'd0, bus.busy}, 32'd0);
    end

    // ten-cycle stalls at t=15 (LOAD) and on W[63]
    load_abc();
    run_block(1, 0, 0, 1, 0, 0, -1, dc, fc);
    check("stall_done_cycle", dc, 32'd86);
    check("stall_q_empty", exp_q.size(), 32'd0);

    // reset in the middle of expansion
    load_abc();
    run_block(1, 0, 0, 0, 0, 0, 39, dc, fc);
    reset = 1'b1;
    bus.w_ready = 1'b0;
    bus.start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check_reset_values("midrst");
    exp_q.delete();
    awaiting_done = 0;
    for (int i = 0; i < 4; i++) begin
      bus.w_ready = 1'b1;
      @(negedge clock);
      check("midrst_no_done", {31'd0, bus.done}, 32'd0);
      @(posedge clock); #1;
    end
    load_abc();
    run_block(1, 0, 0, 0, 0, 0, -1, dc, fc);
    check("post_rst_done_cycle", dc, 32'd66);
    check("post_rst_q_empty", exp_q.size(), 32'd0);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
